// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU, PC adders and cycle counter, all outputs registered
module alu_exec_unit #(
  parameter int DATA_WIDTH = 64,
  parameter int PC_INCR    = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [3:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic [DATA_WIDTH-1:0] pc_in,
  input  logic [DATA_WIDTH-1:0] branch_offset,
  input  logic                  branch,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  carry,
  output logic                  overflow,
  output logic                  illegal_op,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic                  branch_taken,
  output logic                  valid_out,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  localparam int MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH:0]   add_full;
  logic [DATA_WIDTH:0]   sub_full;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  carry_comb;
  logic                  ovf_comb;
  logic                  illegal_comb;
  logic                  zero_comb;
  logic                  slt_bit;
  logic                  sltu_bit;
  logic [DATA_WIDTH-1:0] seq_pc;
  logic [DATA_WIDTH-1:0] target_pc;
  logic                  taken_comb;

  // Subtraction is done as a + ~b + 1 so the carry-out doubles as "no borrow".
  assign add_full = {1'b0, op_a} + {1'b0, op_b};
  assign sub_full = {1'b0, op_a} + {1'b0, ~op_b} + {{DATA_WIDTH{1'b0}}, 1'b1};
  assign slt_bit  = $signed(op_a) < $signed(op_b);
  assign sltu_bit = op_a < op_b;

  always_comb begin
    alu_res      = '0;
    carry_comb   = 1'b0;
    ovf_comb     = 1'b0;
    illegal_comb = 1'b0;
    case (alu_ctrl)
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_NOR:  alu_res = ~(op_a | op_b);
      OP_ADD: begin
        alu_res    = add_full[DATA_WIDTH-1:0];
        carry_comb = add_full[DATA_WIDTH];
        ovf_comb   = (op_a[MSB] == op_b[MSB]) && (add_full[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        alu_res    = sub_full[DATA_WIDTH-1:0];
        carry_comb = sub_full[DATA_WIDTH];
        ovf_comb   = (op_a[MSB] != op_b[MSB]) && (sub_full[MSB] != op_a[MSB]);
      end
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, slt_bit};
      OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, sltu_bit};
      default: illegal_comb = 1'b1;
    endcase
  end

  assign zero_comb = (alu_res == '0);

  // Offset is a halfword count; the shift silently drops its MSB.
  assign seq_pc     = pc_in + DATA_WIDTH'(PC_INCR);
  assign target_pc  = pc_in + {branch_offset[DATA_WIDTH-2:0], 1'b0};
  assign taken_comb = branch & zero_comb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      zero         <= 1'b0;
      carry        <= 1'b0;
      overflow     <= 1'b0;
      illegal_op   <= 1'b0;
      next_pc      <= '0;
      branch_taken <= 1'b0;
      valid_out    <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        result       <= alu_res;
        zero         <= zero_comb;
        carry        <= carry_comb;
        overflow     <= ovf_comb;
        illegal_op   <= illegal_comb;
        next_pc      <= taken_comb ? target_pc : seq_pc;
        branch_taken <= taken_comb;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycle_count <= '0;
    else        cycle_count <= cycle_count + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - table-driven scoreboard bench for alu_exec_unit
module tb_alu_exec_unit;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] pc;
    logic [63:0] off;
    logic        br;
    logic [63:0] res;
    logic        z;
    logic        c;
    logic        v;
    logic        ill;
    logic [63:0] npc;
    logic        bt;
  } vec_t;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [3:0]  alu_ctrl = '0;
  logic [63:0] op_a = '0;
  logic [63:0] op_b = '0;
  logic [63:0] pc_in = '0;
  logic [63:0] branch_offset = '0;
  logic        branch = 1'b0;
  logic [63:0] result;
  logic        zero;
  logic        carry;
  logic        overflow;
  logic        illegal_op;
  logic [63:0] next_pc;
  logic        branch_taken;
  logic        valid_out;
  logic [31:0] cycle_count;

  int          checks = 0;
  int          errors = 0;
  int          tick_no = 0;
  logic [31:0] exp_cnt = '0;
  vec_t        exp_q[$];
  vec_t        tbl[$];
  vec_t        last;
  vec_t        zr;

  alu_exec_unit dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_ctrl(alu_ctrl),
    .op_a(op_a), .op_b(op_b), .pc_in(pc_in), .branch_offset(branch_offset),
    .branch(branch), .result(result), .zero(zero), .carry(carry),
    .overflow(overflow), .illegal_op(illegal_op), .next_pc(next_pc),
    .branch_taken(branch_taken), .valid_out(valid_out), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [3:0] ctrl, logic [63:0] a, logic [63:0] b,
                              logic [63:0] pc, logic [63:0] off, logic br,
                              logic [63:0] res, logic z, logic c, logic v, logic ill,
                              logic [63:0] npc, logic bt);
    vec_t t;
    t.ctrl = ctrl; t.a = a; t.b = b; t.pc = pc; t.off = off; t.br = br;
    t.res = res; t.z = z; t.c = c; t.v = v; t.ill = ill; t.npc = npc; t.bt = bt;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_out(input vec_t e, input logic vo, input string tag);
    chk({tag, ".valid_out"}, {63'b0, valid_out}, {63'b0, vo});
    chk({tag, ".result"}, result, e.res);
    chk({tag, ".zero"}, {63'b0, zero}, {63'b0, e.z});
    chk({tag, ".carry"}, {63'b0, carry}, {63'b0, e.c});
    chk({tag, ".overflow"}, {63'b0, overflow}, {63'b0, e.v});
    chk({tag, ".illegal_op"}, {63'b0, illegal_op}, {63'b0, e.ill});
    chk({tag, ".next_pc"}, next_pc, e.npc);
    chk({tag, ".branch_taken"}, {63'b0, branch_taken}, {63'b0, e.bt});
  endtask

  task automatic drive(input vec_t v);
    valid_in = 1'b1;
    alu_ctrl = v.ctrl; op_a = v.a; op_b = v.b;
    pc_in = v.pc; branch_offset = v.off; branch = v.br;
    exp_q.push_back(v);
  endtask

  task automatic scramble(input logic vin);
    valid_in = vin;
    alu_ctrl = 4'($urandom);
    op_a = {$urandom, $urandom};
    op_b = {$urandom, $urandom};
    pc_in = {$urandom, $urandom};
    branch_offset = {$urandom, $urandom};
    branch = 1'($urandom);
  endtask

  // One clock: sample 1 time unit after the edge, pop whatever the previous cycle launched.
  task automatic tick();
    logic exp_vo;
    @(posedge clk);
    #1;
    if (rst_n) exp_cnt++;
    chk($sformatf("t%0d.cycle_count", tick_no), {32'b0, cycle_count}, {32'b0, exp_cnt});
    exp_vo = (exp_q.size() > 0);
    if (exp_vo) last = exp_q.pop_front();
    check_out(last, exp_vo, $sformatf("t%0d", tick_no));
    tick_no++;
  endtask

  initial begin
    zr   = '0;
    last = zr;

    tbl.push_back(mk(4'b0010, 5, 7, 'h100, 0, 0, 12, 0, 0, 0, 0, 'h104, 0));
    tbl.push_back(mk(4'b0110, 'h55, 'h55, 'h200, 'h10, 1, 0, 1, 1, 0, 0, 'h220, 1));
    tbl.push_back(mk(4'b0110, 'h55, 'h56, 'h200, 'h10, 1, ALL1, 0, 0, 0, 0, 'h204, 0));
    tbl.push_back(mk(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 1, 'h300, 0, 0,
                     64'h8000_0000_0000_0000, 0, 0, 1, 0, 'h304, 0));
    tbl.push_back(mk(4'b0010, ALL1, 1, 'h400, 0, 0, 0, 1, 1, 0, 0, 'h404, 0));
    tbl.push_back(mk(4'b0000, 'hF0F0, 'hFF00, 'h100, 0, 0, 'hF000, 0, 0, 0, 0, 'h104, 0));
    tbl.push_back(mk(4'b1100, 0, 0, 'h100, 0, 0, ALL1, 0, 0, 0, 0, 'h104, 0));
    tbl.push_back(mk(4'b0111, ALL1, 1, 'h100, 0, 0, 1, 0, 0, 0, 0, 'h104, 0));
    tbl.push_back(mk(4'b1000, ALL1, 1, 'h500, 8, 1, 0, 1, 0, 0, 0, 'h510, 1));
    tbl.push_back(mk(4'b1111, 5, 3, 'h100, 0, 0, 0, 1, 0, 0, 1, 'h104, 0));
    tbl.push_back(mk(4'b0001, 'h0F, 'hF0, 'h100, 0, 0, 'hFF, 0, 0, 0, 0, 'h104, 0));
    tbl.push_back(mk(4'b0011, 'hFF, 'h0F, 'h100, 0, 0, 'hF0, 0, 0, 0, 0, 'h104, 0));
    tbl.push_back(mk(4'b0110, 64'h8000_0000_0000_0000, 1, 'h100, 0, 0,
                     64'h7FFF_FFFF_FFFF_FFFF, 0, 1, 1, 0, 'h104, 0));
    tbl.push_back(mk(4'b0010, 0, 0, 'h1000, 64'hFFFF_FFFF_FFFF_FFF8, 1, 0, 1, 0, 0, 0, 'hFF0, 1));
    tbl.push_back(mk(4'b0000, 0, ALL1, 'h10, 64'h8000_0000_0000_0001, 1, 0, 1, 0, 0, 0, 'h12, 1));
    tbl.push_back(mk(4'b0111, 1, ALL1, 'h100, 0, 0, 0, 1, 0, 0, 0, 'h104, 0));
    tbl.push_back(mk(4'b1000, 1, ALL1, 'h100, 0, 0, 1, 0, 0, 0, 0, 'h104, 0));
    tbl.push_back(mk(4'b0100, 5, 3, 'h20, 4, 1, 0, 1, 0, 0, 1, 'h28, 1));
    tbl.push_back(mk(4'b0010, ALL1, ALL1, 'h100, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0, 0, 'h104, 0));
    tbl.push_back(mk(4'b0110, 3, 5, 'h100, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0, 'h104, 0));
    tbl.push_back(mk(4'b0110, 5, 3, 'h100, 0, 0, 2, 0, 1, 0, 0, 'h104, 0));

    // Reset held with live-looking inputs: nothing may come out.
    scramble(1'b1);
    tick();
    scramble(1'b1);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    scramble(1'b0);
    for (int i = 0; i < 3; i++) tick();

    // Back-to-back operations, one per cycle.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      tick();
    end

    // Idle cycles: registers hold the last result.
    for (int i = 0; i < 3; i++) begin
      scramble(1'b0);
      tick();
    end

    // Async reset between edges discards the in-flight op.
    drive(tbl[0]);
    tick();
    drive(tbl[3]);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    last    = zr;
    exp_cnt = '0;
    check_out(zr, 1'b0, "async_rst");
    chk("async_rst.cycle_count", {32'b0, cycle_count}, 64'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    scramble(1'b0);
    tick();
    drive(tbl[4]);
    tick();
    scramble(1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
